// File: rtl/alu_pkg.sv
// Opcode encodings and flag bit positions shared by alu_pipe, its shifter and the bench.
package alu_pkg;

  localparam logic [4:0] ADD  = 5'd0;
  localparam logic [4:0] ADC  = 5'd1;
  localparam logic [4:0] SUB  = 5'd2;
  localparam logic [4:0] SBB  = 5'd3;
  localparam logic [4:0] NEG  = 5'd4;
  localparam logic [4:0] INC  = 5'd5;
  localparam logic [4:0] DEC  = 5'd6;
  localparam logic [4:0] PASS = 5'd7;
  localparam logic [4:0] AND  = 5'd8;
  localparam logic [4:0] OR   = 5'd9;
  localparam logic [4:0] XOR  = 5'd10;
  localparam logic [4:0] COMP = 5'd11;
  localparam logic [4:0] ASL  = 5'd12;
  localparam logic [4:0] ASR  = 5'd13;
  localparam logic [4:0] LSL  = 5'd14;
  localparam logic [4:0] LSR  = 5'd15;
  localparam logic [4:0] ROL  = 5'd16;
  localparam logic [4:0] ROR  = 5'd17;
  localparam logic [4:0] RCL  = 5'd18;
  localparam logic [4:0] RCR  = 5'd19;
  localparam logic [4:0] OP_LAST = 5'd19;

  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_P    = 4;
  localparam int NUM_FLAGS = 5;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle for alu_pipe; master drives operations, slave is the ALU.
interface alu_pipe_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             flag_p;
  logic             illegal;

  modport master (
    output in_valid, opcode, operand_a, operand_b, carry_in, out_ready,
    input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, flag_p, illegal
  );

  modport slave (
    input  in_valid, opcode, operand_a, operand_b, carry_in, out_ready,
    output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v, flag_p, illegal
  );

endinterface

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit for alu_pipe opcodes ASL..RCR; returns result, carry and ASL overflow.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_amt,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH:0]   w_left;
  logic [WIDTH:0]   w_right;
  logic [WIDTH:0]   w_rightArith;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic             w_aslV;

  // One extra bit on the outgoing side of each shift catches the last bit shifted out.
  always_comb begin
    w_left       = {1'b0, i_a} << i_amt;
    w_right      = {i_a, 1'b0} >> i_amt;
    w_rightArith = $signed({i_a, 1'b0}) >>> i_amt;
    w_rol        = (i_a << i_amt) | (i_a >> (WIDTH - int'(i_amt)));
    w_ror        = (i_a >> i_amt) | (i_a << (WIDTH - int'(i_amt)));
    w_aslV       = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i >= WIDTH - int'(i_amt)) && (i_a[i] != w_left[WIDTH-1])) begin
        w_aslV = 1'b1;
      end
    end
  end

  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_op)
      ASL: begin
        o_result   = w_left[WIDTH-1:0];
        o_carry    = w_left[WIDTH];
        o_overflow = w_aslV;
      end
      LSL: begin
        o_result = w_left[WIDTH-1:0];
        o_carry  = w_left[WIDTH];
      end
      ASR: begin
        o_result = w_rightArith[WIDTH:1];
        o_carry  = w_rightArith[0];
      end
      LSR: begin
        o_result = w_right[WIDTH:1];
        o_carry  = w_right[0];
      end
      ROL: begin
        o_result = w_rol;
        o_carry  = w_rol[0];
      end
      ROR: begin
        o_result = w_ror;
        o_carry  = w_ror[WIDTH-1];
      end
      RCL: begin
        o_result = {i_a[WIDTH-2:0], i_cin};
        o_carry  = i_a[WIDTH-1];
      end
      RCR: begin
        o_result = {i_cin, i_a[WIDTH-1:1]};
        o_carry  = i_a[0];
      end
      default: begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshake and full flag set.
// Optional build macro SAT_ARITH_EN: signed saturation for ADD/ADC/SUB/SBB/NEG/INC/DEC.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE  = {{WIDTH{1'b0}}, 1'b1};

  logic                 r_s1Valid;
  logic [4:0]           r_s1Op;
  logic [WIDTH-1:0]     r_s1A;
  logic [WIDTH-1:0]     r_s1B;
  logic                 r_s1Cin;
  logic                 r_outValid;
  logic [WIDTH-1:0]     r_result;
  logic [NUM_FLAGS-1:0] r_flags;
  logic                 r_illegal;

  logic                 w_advance;
  logic [WIDTH:0]       w_arith;
  logic [WIDTH:0]       w_cinExt;
  logic [WIDTH-1:0]     w_result;
  logic                 w_c;
  logic                 w_v;
  logic                 w_illegal;
  logic [NUM_FLAGS-1:0] w_flags;
  logic                 w_aSign;
  logic                 w_bSign;
  logic [WIDTH-1:0]     w_shResult;
  logic                 w_shCarry;
  logic                 w_shOverflow;

  assign w_advance = !r_outValid || bus.out_ready;
  assign w_cinExt  = {{WIDTH{1'b0}}, r_s1Cin};
  assign w_aSign   = r_s1A[WIDTH-1];
  assign w_bSign   = r_s1B[WIDTH-1];

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .i_op       (r_s1Op),
    .i_a        (r_s1A),
    .i_amt      (r_s1B[SHW-1:0]),
    .i_cin      (r_s1Cin),
    .o_result   (w_shResult),
    .o_carry    (w_shCarry),
    .o_overflow (w_shOverflow)
  );

  // Stage 2 datapath: arithmetic runs at WIDTH+1 bits so the top bit is carry/borrow.
  always_comb begin
    w_arith   = '0;
    w_result  = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_illegal = 1'b0;
    case (r_s1Op)
      ADD, ADC: begin
        w_arith  = {1'b0, r_s1A} + {1'b0, r_s1B} + ((r_s1Op == ADC) ? w_cinExt : '0);
        w_result = w_arith[WIDTH-1:0];
        w_c      = w_arith[WIDTH];
        w_v      = (w_aSign == w_bSign) && (w_arith[WIDTH-1] != w_aSign);
      end
      SUB, SBB: begin
        w_arith  = {1'b0, r_s1A} - {1'b0, r_s1B} - ((r_s1Op == SBB) ? w_cinExt : '0);
        w_result = w_arith[WIDTH-1:0];
        w_c      = w_arith[WIDTH];
        w_v      = (w_aSign != w_bSign) && (w_arith[WIDTH-1] != w_aSign);
      end
      NEG: begin
        w_arith  = '0 - {1'b0, r_s1A};
        w_result = w_arith[WIDTH-1:0];
        w_c      = (r_s1A != '0);
        w_v      = (r_s1A == MINV);
      end
      INC: begin
        w_arith  = {1'b0, r_s1A} + ONE;
        w_result = w_arith[WIDTH-1:0];
        w_c      = (r_s1A == '1);
        w_v      = (r_s1A == MAXV);
      end
      DEC: begin
        w_arith  = {1'b0, r_s1A} - ONE;
        w_result = w_arith[WIDTH-1:0];
        w_c      = (r_s1A == '0);
        w_v      = (r_s1A == MINV);
      end
      PASS: w_result = r_s1A;
      AND:  w_result = r_s1A & r_s1B;
      OR:   w_result = r_s1A | r_s1B;
      XOR:  w_result = r_s1A ^ r_s1B;
      COMP: w_result = ~r_s1A;
      ASL, ASR, LSL, LSR, ROL, ROR, RCL, RCR: begin
        w_result = w_shResult;
        w_c      = w_shCarry;
        w_v      = w_shOverflow;
      end
      default: w_illegal = 1'b1;
    endcase

`ifdef SAT_ARITH_EN
    // Wrapped sign is the opposite of the true sign, so it picks the clamp direction.
    if ((r_s1Op <= DEC) && w_v) begin
      w_result = w_result[WIDTH-1] ? MAXV : MINV;
    end
`endif

    w_flags         = '0;
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
    w_flags[FLAG_Z] = (w_result == '0);
    w_flags[FLAG_N] = w_result[WIDTH-1];
    w_flags[FLAG_P] = ~^w_result;
    if (w_illegal) begin
      w_flags         = '0;
      w_flags[FLAG_Z] = 1'b1;
    end
  end

  // Control and result registers; both stages hold together while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid  <= 1'b0;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_illegal  <= 1'b0;
    end else if (w_advance) begin
      r_s1Valid  <= bus.in_valid;
      r_outValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_result  <= w_result;
        r_flags   <= w_flags;
        r_illegal <= w_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance && bus.in_valid) begin
      r_s1Op  <= bus.opcode;
      r_s1A   <= bus.operand_a;
      r_s1B   <= bus.operand_b;
      r_s1Cin <= bus.carry_in;
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_outValid;
  assign bus.result    = r_result;
  assign bus.flag_c    = r_flags[FLAG_C];
  assign bus.flag_z    = r_flags[FLAG_Z];
  assign bus.flag_n    = r_flags[FLAG_N];
  assign bus.flag_v    = r_flags[FLAG_V];
  assign bus.flag_p    = r_flags[FLAG_P];
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8 (expectations follow SAT_ARITH_EN if defined).
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  alu_pipe_if #(.WIDTH(8)) bus ();

  alu_pipe #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.carry_in  = cin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, ".outValid"}, bus.out_valid, 1);
  endtask

  task automatic checkResult(input string tag, input logic [7:0] res, input logic c, input logic z,
                             input logic n, input logic v, input logic p, input logic ill);
    checkOutput({tag, ".result"}, bus.result, res);
    checkOutput({tag, ".C"}, bus.flag_c, c);
    checkOutput({tag, ".Z"}, bus.flag_z, z);
    checkOutput({tag, ".N"}, bus.flag_n, n);
    checkOutput({tag, ".V"}, bus.flag_v, v);
    checkOutput({tag, ".P"}, bus.flag_p, p);
    checkOutput({tag, ".illegal"}, bus.illegal, ill);
  endtask

  task automatic runVector(input string tag, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] res, input logic c, input logic z,
                           input logic n, input logic v, input logic p, input logic ill);
    applyStimulus(op, a, b, cin);
    waitResult(tag);
    checkResult(tag, res, c, z, n, v, p, ill);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount    = 0;
    failCount     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.outValid", bus.out_valid, 0);
    checkOutput("reset.inReady", bus.in_ready, 1);
    checkResult("reset", 8'h00, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Arithmetic: overflow, borrow, saturation-sensitive cases.
`ifdef SAT_ARITH_EN
    runVector("addOvf", ADD, 8'h7F, 8'h01, 0, 8'h7F, 0, 0, 0, 1, 0, 0);
    runVector("negMin", NEG, 8'h80, 8'h00, 0, 8'h7F, 1, 0, 0, 1, 0, 0);
`else
    runVector("addOvf", ADD, 8'h7F, 8'h01, 0, 8'h80, 0, 0, 1, 1, 0, 0);
    runVector("negMin", NEG, 8'h80, 8'h00, 0, 8'h80, 1, 0, 1, 1, 0, 0);
`endif
    runVector("subBorrow", SUB, 8'h00, 8'h01, 0, 8'hFF, 1, 0, 1, 0, 1, 0);
    runVector("sbbCin",    SBB, 8'h05, 8'h05, 1, 8'hFF, 1, 0, 1, 0, 1, 0);
    runVector("decZero",   DEC, 8'h00, 8'h00, 0, 8'hFF, 1, 0, 1, 0, 1, 0);
    runVector("andMask",   AND, 8'hF0, 8'h3C, 0, 8'h30, 0, 0, 0, 0, 1, 0);
    runVector("xorZero",   XOR, 8'h55, 8'h55, 0, 8'h00, 0, 1, 0, 0, 1, 0);

    // Shifts and rotates.
    runVector("asr3",  ASR, 8'h81, 8'h03, 0, 8'hF0, 0, 0, 1, 0, 1, 0);
    runVector("lsr1",  LSR, 8'h81, 8'h01, 0, 8'h40, 1, 0, 0, 0, 0, 0);
    runVector("rcl",   RCL, 8'h80, 8'h00, 1, 8'h01, 1, 0, 0, 0, 0, 0);
    runVector("aslV",  ASL, 8'h40, 8'h01, 0, 8'h80, 0, 0, 1, 1, 0, 0);
    runVector("ror1",  ROR, 8'h01, 8'h01, 0, 8'h80, 1, 0, 1, 0, 0, 0);

    // Back-to-back A, B, C with a three-cycle consumer stall after the first result.
    bus.in_valid  = 1'b1;
    bus.opcode    = ADD;  bus.operand_a = 8'h01; bus.operand_b = 8'h02; bus.carry_in = 1'b0;
    @(posedge clk); #1;
    bus.opcode    = XOR;  bus.operand_a = 8'h0F; bus.operand_b = 8'hFF;
    @(posedge clk); #1;
    checkOutput("b2b.firstValid", bus.out_valid, 1);
    checkOutput("b2b.firstResult", bus.result, 8'h03);
    bus.opcode    = INC;  bus.operand_a = 8'h41; bus.operand_b = 8'h00;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("b2b.stallInReady", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("b2b.holdValid", bus.out_valid, 1);
      checkOutput("b2b.holdResult", bus.result, 8'h03);
      checkOutput("b2b.holdInReady", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("b2b.releaseInReady", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("b2b.secondValid", bus.out_valid, 1);
    checkOutput("b2b.secondResult", bus.result, 8'hF0);
    @(posedge clk); #1;
    checkOutput("b2b.thirdValid", bus.out_valid, 1);
    checkOutput("b2b.thirdResult", bus.result, 8'h42);
    @(posedge clk); #1;
    checkOutput("b2b.drained", bus.out_valid, 0);

    // Illegal opcode, then reset with two operations in flight.
    runVector("illegal25", 5'd25, 8'hAA, 8'h55, 1, 8'h00, 0, 1, 0, 0, 0, 1);
    applyStimulus(ADD, 8'h10, 8'h20, 0);
    bus.in_valid  = 1'b1;
    bus.opcode    = SUB;  bus.operand_a = 8'h30; bus.operand_b = 8'h10;
    rst           = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstFlight.outValid", bus.out_valid, 0);
    checkOutput("rstFlight.illegal", bus.illegal, 0);
    checkOutput("rstFlight.result", bus.result, 8'h00);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("rstFlight.noEmit", bus.out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined integer ALU; successor to the 8-bit single-cycle ALU in the datapath. Executes 20 opcodes at a configurable WIDTH. Uses a valid/ready handshake on input and output and produces a full flag set: carry, zero, negative, overflow, parity and illegal-opcode. Sits between the operand-fetch stage and the writeback/flag register.

Parameters:
WIDTH, 8, operand/result width in bits (must be >= 4).
SHW, $clog2(WIDTH), width of the shift-amount field taken from operand_b.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation presented
in_ready  out  1  block accepts operation this cycle
opcode  in  5  operation select (encodings in alu_pkg)
operand_a  in  WIDTH  operand A
operand_b  in  WIDTH  operand B; bits [SHW-1:0] give the shift/rotate amount
carry_in  in  1  carry for ADC, borrow for SBB, rotate-in bit for RCL/RCR
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  WIDTH  result
flag_c, flag_z, flag_n, flag_v, flag_p  out  1 each  carry/borrow, zero, negative, signed overflow, parity
illegal  out  1  opcode was outside 0..19

Behaviour:
- Reset and clocking: reset is rst, synchronous, active-high; clock is clk. Reset clears s1_valid, out_valid, result, all flags and illegal to 0. An operation in flight during reset is discarded.
- Pipeline: stage 1 registers opcode, operands and carry_in. Stage 2 computes and registers result and flags.
- Stall: advance = !out_valid || out_ready, and in_ready = advance. When advance is low, both stages hold.
- Latency: 2 cycles from accepted input to out_valid. Throughput is 1 operation per cycle with no bubbles while out_ready stays high.
- Outputs stay stable while out_valid && !out_ready.
- Arithmetic is computed at WIDTH+1 bits. C = bit WIDTH. V = two's-complement overflow (operand signs equal and result sign differs; for subtraction, A sign != B sign and result sign != A sign).
- ADD: A+B. ADC: A+B+cin. SUB: A-B, C=borrow (A<B unsigned). SBB: A-B-cin, C=borrow.
- NEG: 0-A, C=(A!=0), V=(A==MIN).
- INC: C=(A==all ones), V=(A==MAX). DEC: C=(A==0), V=(A==MIN).
- PASS: A. AND, OR, XOR: A op B. COMP: ~A. For all of these, C=V=0.
- Shifts by amount s=B[SHW-1:0]. ASL/LSL: A<<s. ASR: sign fill. LSR: zero fill.
  - C = last bit shifted out; C=0 when s=0.
  - V = 0, except ASL where V=1 if any shifted-out bit differs from the result MSB.
- ROL/ROR: rotate by s, C = result LSB (ROL) or MSB (ROR), V=0.
- RCL/RCR: rotate by 1 through cin (ignores s). C = bit rotated out, V=0.
- Z = (result==0). N = result[WIDTH-1]. P = ~^result (1 = even number of ones).
- Opcodes 20..31: result=0, C=V=N=P=0, Z=1, illegal=1. Legal opcodes drive illegal=0.

Optional Feature:
SAT_ARITH_EN:
- Defined: ADD/ADC/SUB/SBB/INC/DEC/NEG saturate on signed overflow. Result clamps to MAX (positive overflow) or MIN (negative overflow); V still reports overflow; C is unchanged.
- Undefined: results wrap modulo 2^WIDTH.

Decomposition:
- alu_pkg holds the opcode localparams:
  - ADD=0, ADC=1, SUB=2, SBB=3, NEG=4, INC=5, DEC=6, PASS=7
  - AND=8, OR=9, XOR=10, COMP=11
  - ASL=12, ASR=13, LSL=14, LSR=15, ROL=16, ROR=17, RCL=18, RCR=19
  - OP_LAST=19, and the flag bit indices.
- Sub-module alu_shifter (combinational, parametrised WIDTH) handles all shift/rotate opcodes and returns result and C.

Test Plan (WIDTH=8):
1. ADD 0x7F+0x01 -> result 0x80, V=1, N=1, C=0, Z=0, P=0. With SAT_ARITH_EN -> result 0x7F, V=1.
2. SUB 0x00-0x01 -> 0xFF, C=1, N=1, V=0. SBB 0x05-0x05 with cin=1 -> 0xFF, C=1.
3. ASR 0x81, B=3 -> 0xF0, C=0. LSR 0x81, B=1 -> 0x40, C=1. RCL 0x80 with cin=1 -> 0x01, C=1.
4. Back-to-back ops A, B, C; hold out_ready=0 for 3 cycles after the first result -> in_ready=0, result A held stable; release -> A, B, C appear in order, none lost or duplicated.
5. opcode 25 -> illegal=1, result 0, Z=1. Assert rst while 2 ops are in flight -> out_valid=0 the next cycle, and neither op is ever emitted.
